// File: rtl/finn_rtl_krnl_final_example_stream_checker.sv
// Stream checker: consumes an AXI4-Stream carrying a counting pattern and
// reports beats received, per-beat errors and an overall pass flag.
//
// Handshake: a beat is transferred on a rising aclk edge when s_axis_tvalid
// and s_axis_tready are both high; s_axis_tready is high only while a check
// is running, and the upstream must hold tdata/tkeep/tlast stable while
// tvalid is high and tready is low.
module finn_rtl_krnl_final_example_stream_checker #(
  parameter int C_S_AXIS_TDATA_WIDTH = 128,
  parameter int C_NUMBER_BIT_WIDTH   = 32,
  parameter int C_LENGTH_IN_BYTES    = 16384
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic                              ap_start,
  output logic                              ap_done,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                              s_axis_tlast,
  output logic [31:0]                       error_count,
  output logic [31:0]                       beat_count,
  output logic                              pass,
  output logic [1:0]                        dbg_state_o
);

  localparam int DW = C_S_AXIS_TDATA_WIDTH;
  localparam int KW = DW / 8;
  localparam int L  = (C_NUMBER_BIT_WIDTH < DW) ? C_NUMBER_BIT_WIDTH : DW;
  localparam int G  = DW / L;
  localparam int S  = (G > 1) ? $clog2(G) : 0;
  localparam int NB = (C_LENGTH_IN_BYTES + KW - 1) / KW;
  localparam int P  = C_LENGTH_IN_BYTES % KW;

  localparam logic [31:0]   NB_M1     = 32'(NB - 1);
  localparam logic [KW-1:0] KEEP_ALL  = '1;
  localparam logic [KW-1:0] KEEP_LAST = (P == 0) ? KEEP_ALL : ~(KEEP_ALL << P);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] err_q, err_d;
  logic [31:0] beats_q, beats_d;
  logic [31:0] b_q, b_d;
  logic        pass_q, pass_d;
  logic        ap_start_q;
  logic        arm_q;

  logic          start;
  logic          accept;
  logic          is_last_idx;
  logic [DW-1:0] exp_word;
  logic [DW-1:0] keep_mask;
  logic [KW-1:0] keep_exp;
  logic          data_bad;
  logic          keep_bad;
  logic          last_bad;
  logic          beat_err;

  // arm_q only rises once ap_start has been seen low, so a level held high
  // through reset cannot masquerade as a fresh rising edge.
  assign start  = ap_start & ~ap_start_q & arm_q;
  assign accept = s_axis_tvalid & s_axis_tready;

  // Expected pattern: lane n of beat b carries {b, n} truncated to the lane.
  always_comb begin
    exp_word = '0;
    for (int n = 0; n < G; n++) begin
      exp_word[n*L +: L] = (L'(b_q) << S) | L'(n);
    end
  end

  // Expand tkeep into a bit mask so only kept bytes take part in the compare.
  always_comb begin
    keep_mask = '0;
    for (int k = 0; k < KW; k++) begin
      keep_mask[k*8 +: 8] = {8{s_axis_tkeep[k]}};
    end
  end

  assign is_last_idx = (b_q == NB_M1);
  assign keep_exp    = is_last_idx ? KEEP_LAST : KEEP_ALL;
  assign data_bad    = |((s_axis_tdata ^ exp_word) & keep_mask);
  assign keep_bad    = (s_axis_tkeep != keep_exp);
  assign last_bad    = (s_axis_tlast != is_last_idx);
  assign beat_err    = data_bad | keep_bad | last_bad;

  // Next-state logic: start clears the run, each accepted beat updates counters.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    beats_d = beats_q;
    b_d     = b_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          err_d   = '0;
          beats_d = '0;
          b_d     = '0;
          pass_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          b_d     = b_q + 32'd1;
          beats_d = (beats_q == '1) ? beats_q : beats_q + 32'd1;
          if (beat_err) begin
            err_d = (err_q == '1) ? err_q : err_q + 32'd1;
          end
          if (is_last_idx || s_axis_tlast) begin
            state_d = ST_DONE;
            pass_d  = (err_d == '0);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      err_q      <= '0;
      beats_q    <= '0;
      b_q        <= '0;
      pass_q     <= 1'b0;
      ap_start_q <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      beats_q    <= beats_d;
      b_q        <= b_d;
      pass_q     <= pass_d;
      ap_start_q <= ap_start;
      arm_q      <= arm_q | ~ap_start;
    end
  end

  assign s_axis_tready = (state_q == ST_RUN);
  assign ap_done       = (state_q == ST_DONE);
  assign error_count   = err_q;
  assign beat_count    = beats_q;
  assign pass          = pass_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_finn_rtl_krnl_final_example_stream_checker.sv
module tb_finn_rtl_krnl_final_example_stream_checker;

  // ---------------- clock / reset ----------------
  logic aclk;
  logic areset;
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic         ap_start, ap_start2;
  logic         s_axis_tvalid;
  logic [127:0] s_axis_tdata;
  logic [15:0]  s_axis_tkeep;
  logic         s_axis_tlast;

  logic         ap_done, tready, pass;
  logic [31:0]  error_count, beat_count;
  logic [1:0]   dbg_state;

  logic         ap_done2, tready2, pass2;
  logic [31:0]  error_count2, beat_count2;
  logic [1:0]   dbg_state2;

  int checks = 0;
  int errors = 0;

  finn_rtl_krnl_final_example_stream_checker dut (
    .aclk(aclk), .areset(areset), .ap_start(ap_start), .ap_done(ap_done),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .error_count(error_count),
    .beat_count(beat_count), .pass(pass), .dbg_state_o(dbg_state)
  );

  // Short transfer: 20 bytes on a 128-bit bus -> 2 beats, last tkeep 16'h000F.
  finn_rtl_krnl_final_example_stream_checker #(
    .C_S_AXIS_TDATA_WIDTH(128), .C_NUMBER_BIT_WIDTH(32), .C_LENGTH_IN_BYTES(20)
  ) dut2 (
    .aclk(aclk), .areset(areset), .ap_start(ap_start2), .ap_done(ap_done2),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(tready2),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .error_count(error_count2),
    .beat_count(beat_count2), .pass(pass2), .dbg_state_o(dbg_state2)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  // Upstream generator: lane n of beat b = 4*b + n (32-bit lanes, 4 per beat).
  function automatic logic [127:0] beat_word(input int b);
    logic [127:0] w;
    for (int n = 0; n < 4; n++) w[32*n +: 32] = 32'(4 * b + n);
    return w;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    int   tlast_at;    // beat with an injected early tlast, -1 none
    int   corrupt_at;  // beat whose lane 2 is off by one, -1 none
    int   keep_at;     // beat with a wrong tkeep, -1 none
    int   gap_max;     // max idle cycles before each beat
    int   abort_at;    // stop driving after this many beats, -1 run to end
    int   exp_beats;
    int   exp_err;
    logic exp_pass;
  } run_vec_t;

  run_vec_t vecs[6];
  run_vec_t abort_vec;
  run_vec_t clean_vec;

  // ---------------- driver ----------------
  task automatic run_check(input run_vec_t v, input int idx);
    int b;
    int g;
    bit fin;
    logic [127:0] d;
    ap_start = 1'b0;
    s_axis_tvalid = 1'b0;
    @(posedge aclk); #1;
    ap_start = 1'b1;
    @(posedge aclk); #1;
    check1($sformatf("v%0d_tready_run", idx), tready, 1'b1);
    check1($sformatf("v%0d_pass_cleared", idx), pass, 1'b0);
    fin = 0;
    b = 0;
    while (!fin && b != v.abort_at && b < 1024) begin
      g = (v.gap_max > 0) ? $urandom_range(v.gap_max, 0) : 0;
      for (int i = 0; i < g; i++) begin
        s_axis_tvalid = 1'b0;
        @(posedge aclk); #1;
        check($sformatf("v%0d_gap_beats_b%0d", idx, b), beat_count, 32'(b));
      end
      d = beat_word(b);
      if (b == v.corrupt_at) d[95:64] = d[95:64] + 32'd1;
      s_axis_tdata  = d;
      s_axis_tkeep  = (b == v.keep_at) ? 16'h7FFF : 16'hFFFF;
      s_axis_tlast  = (b == 1023) || (b == v.tlast_at);
      ap_start      = (b != 300);  // an extra edge mid-run must be ignored
      s_axis_tvalid = 1'b1;
      if (tready !== 1'b1) begin
        check1($sformatf("v%0d_tready_b%0d", idx, b), tready, 1'b1);
        s_axis_tvalid = 1'b0;
        return;
      end
      @(posedge aclk); #1;
      s_axis_tvalid = 1'b0;
      fin = s_axis_tlast;
      b++;
      if (!fin) check1($sformatf("v%0d_done_early_b%0d", idx, b), ap_done, 1'b0);
    end
    if (v.abort_at >= 0) return;
    check1($sformatf("v%0d_ap_done", idx), ap_done, 1'b1);
    check($sformatf("v%0d_beat_count", idx), beat_count, 32'(v.exp_beats));
    check($sformatf("v%0d_error_count", idx), error_count, 32'(v.exp_err));
    check1($sformatf("v%0d_pass", idx), pass, v.exp_pass);
    @(posedge aclk); #1;
    check1($sformatf("v%0d_done_one_cycle", idx), ap_done, 1'b0);
    check1($sformatf("v%0d_pass_hold", idx), pass, v.exp_pass);
    @(posedge aclk); #1;
    check1($sformatf("v%0d_no_restart", idx), tready, 1'b0);
    check($sformatf("v%0d_beats_hold_idle", idx), beat_count, 32'(v.exp_beats));
    ap_start = 1'b0;
  endtask

  task automatic run2(input logic [15:0] last_keep, input int exp_err, input logic exp_pass, input int idx);
    ap_start2 = 1'b0;
    @(posedge aclk); #1;
    ap_start2 = 1'b1;
    @(posedge aclk); #1;
    check1($sformatf("s%0d_tready", idx), tready2, 1'b1);
    check1($sformatf("s%0d_main_idle", idx), tready, 1'b0);
    s_axis_tdata = beat_word(0); s_axis_tkeep = 16'hFFFF; s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b1;
    @(posedge aclk); #1;
    check($sformatf("s%0d_beats_1", idx), beat_count2, 32'd1);
    check1($sformatf("s%0d_done_early", idx), ap_done2, 1'b0);
    s_axis_tdata = beat_word(1); s_axis_tkeep = last_keep; s_axis_tlast = 1'b1;
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    check1($sformatf("s%0d_ap_done", idx), ap_done2, 1'b1);
    check($sformatf("s%0d_beats", idx), beat_count2, 32'd2);
    check($sformatf("s%0d_errors", idx), error_count2, 32'(exp_err));
    check1($sformatf("s%0d_pass", idx), pass2, exp_pass);
    @(posedge aclk); #1;
    check1($sformatf("s%0d_done_off", idx), ap_done2, 1'b0);
    ap_start2 = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    //         tlast corrupt keep gap abort beats err pass
    vecs[0] = '{-1,   -1,     -1,  0, -1,  1024, 0, 1'b1};
    vecs[1] = '{-1,   -1,     -1,  5, -1,  1024, 0, 1'b1};
    vecs[2] = '{-1,   10,     20,  0, -1,  1024, 2, 1'b0};
    vecs[3] = '{99,   -1,     -1,  0, -1,  100,  1, 1'b0};
    vecs[4] = '{50,   50,     50,  2, -1,  51,   1, 1'b0};
    vecs[5] = '{-1,   -1,     -1,  1, -1,  1024, 0, 1'b1};
    abort_vec = '{-1, -1, -1, 0, 500, 0, 0, 1'b0};
    clean_vec = '{-1, -1, -1, 0, -1, 1024, 0, 1'b1};

    areset = 1'b1;
    ap_start = 1'b0; ap_start2 = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
    #1;
    check1("rst_tready", tready, 1'b0);
    check1("rst_ap_done", ap_done, 1'b0);
    check1("rst_pass", pass, 1'b0);
    check("rst_error_count", error_count, 32'd0);
    check("rst_beat_count", beat_count, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check("rst_state2", {30'd0, dbg_state2}, 32'd0);
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    for (int i = 0; i < 6; i++) run_check(vecs[i], i);

    // Reset in the middle of a run: everything clears, no ap_done.
    run_check(abort_vec, 90);
    check("abort_beats_before_rst", beat_count, 32'd500);
    areset = 1'b1;
    #1;
    check1("mid_rst_tready", tready, 1'b0);
    check1("mid_rst_ap_done", ap_done, 1'b0);
    check1("mid_rst_pass", pass, 1'b0);
    check("mid_rst_errors", error_count, 32'd0);
    check("mid_rst_beats", beat_count, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk); #1;
      check1($sformatf("in_rst_ap_done_%0d", i), ap_done, 1'b0);
    end
    areset = 1'b0;
    // ap_start still high from the aborted run: must not start by itself.
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk); #1;
      check1($sformatf("post_rst_no_start_%0d", i), tready, 1'b0);
    end
    run_check(clean_vec, 91);

    // Short transfer on the second instance.
    run2(16'hFFFF, 1, 1'b0, 0);
    run2(16'h000F, 0, 1'b1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
